posit_accum_seq: RTL and testbench

Sequential posit accumulator that consumes a stream of N-bit posit operands over a valid/ready handshake and reduces each group, delimited by `in_last`, to a single posit sum. It sits directly around the combinational posit adder `posit_add_nodsp`. It feeds the adder the running sum and the incoming term, registers the adder result back into the accumulator, and presents one result per group on an output valid/ready port.

---
 rtl/posit_pkg.sv | 34 +++
 rtl/posit_accum_seq_if.sv | 35 +++
 rtl/posit_add_nodsp.sv | 120 ++++++++++++
 rtl/posit_accum_seq.sv | 152 +++++++++++++++
 tb/tb_posit_accum_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : posit_pkg
// Purpose : Shared types and helpers for the posit accumulator slice.
//           - state_e  : accumulator FSM states (WAIT only used when the
//                        pipelined build is selected)
//           - NAR/ZERO : special posit encodings at POSIT_N bits
//           - is_nar / is_zero : encoding tests
// Revision: 1.0 - initial release
// ============================================================================
package posit_pkg;

  localparam int POSIT_N = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [POSIT_N-1:0] NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] ZERO = '0;

  function automatic logic is_nar(input logic [POSIT_N-1:0] v);
    return v == NAR;
  endfunction

  function automatic logic is_zero(input logic [POSIT_N-1:0] v);
    return v == ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_accum_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : posit_accum_seq_if
// Purpose : Operand stream (valid/ready/data/last) and result stream
//           (valid/ready/data/inf/zero/count) of the posit accumulator.
//           master : producer of operands / consumer of results
//           slave  : the accumulator itself
// Revision: 1.0 - initial release
// ============================================================================
interface posit_accum_seq_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_inf;
  logic             out_zero;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_inf, out_zero, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_inf, out_zero, out_count
  );
endinterface
`default_nettype wire

// File: rtl/posit_add_nodsp.sv
`default_nettype none
// ============================================================================
// Module  : posit_add_nodsp
// Purpose : Combinational posit adder (no DSP blocks), round to nearest even,
//           saturating at maxpos/minpos, NaR in -> NaR out.
// Ports   : in1, in2 - posit operands (two's-complement encoding)
//           start    - request; done simply mirrors it (purely combinational)
//           out      - posit sum
//           inf      - either operand is NaR
//           done     - result valid
// Revision: 1.0 - initial release
// ============================================================================
module posit_add_nodsp #(
  parameter int N  = 16,
  parameter int es = 3
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         done
);
  localparam int SW = $clog2(N) + es + 3;  // signed scale width
  localparam int MW = 2 * N;               // aligned significand width
  localparam int L  = 3 * N + es + 2;      // encode bit-string width

  // Split a posit into sign, scale (2^scale) and significand 1.frac (MSB=1).
  // Zero decodes with an all-zero significand so it always loses the
  // magnitude compare.
  function automatic void decode(input  logic [N-1:0]          v,
                                 output logic                  s,
                                 output logic signed [SW-1:0]  sc,
                                 output logic [N-1:0]          m);
    logic [N-2:0]  rem, sh, frac;
    logic          r, stop;
    logic [es-1:0] e;
    int            run, k;
    s    = v[N-1];
    rem  = s ? (~v[N-2:0] + (N-1)'(1)) : v[N-2:0];
    r    = rem[N-2];
    run  = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && rem[i] == r) run++;
      else                      stop = 1'b1;
    end
    sh   = rem << (run + 1);
    e    = sh[N-2 -: es];
    frac = sh << es;
    k    = r ? run - 1 : -run;
    sc   = SW'(k * (2 ** es) + int'(e));
    m    = (v == '0) ? '0 : {1'b1, frac};
  endfunction

  logic               s1, s2, sb, ss, swap, stk, run_bit, guard, up;
  logic signed [SW-1:0] sc1, sc2, scb, scs;
  logic [N-1:0]       m1, m2, mb, ms, mag;
  logic [MW-1:0]      mbx, msx, al, f;
  logic [MW:0]        sum;
  logic [es-1:0]      e;
  logic [L-1:0]       xs, str;
  logic [N-2:0]       field;
  int                 d, p, nsc, k, rm;

  always_comb begin
    decode(in1, s1, sc1, m1);
    decode(in2, s2, sc2, m2);

    swap = (sc2 > sc1) || ((sc2 == sc1) && (m2 > m1));
    sb   = swap ? s2  : s1;
    ss   = swap ? s1  : s2;
    scb  = swap ? sc2 : sc1;
    scs  = swap ? sc1 : sc2;
    mb   = swap ? m2  : m1;
    ms   = swap ? m1  : m2;

    // Align the smaller operand; shifted-out bits fold into a sticky LSB.
    d     = int'(scb) - int'(scs);
    mbx   = {mb, {N{1'b0}}};
    msx   = {ms, {N{1'b0}}};
    al    = msx >> d;
    stk   = ((al << d) != msx);
    al[0] = al[0] | stk;
    sum   = (sb == ss) ? ({1'b0, mbx} + {1'b0, al}) : ({1'b0, mbx} - {1'b0, al});

    // Normalise: leading one moves to bit MW and is dropped.
    p = 0;
    for (int i = 0; i <= MW; i++) begin
      if (sum[i]) p = i;
    end
    nsc = int'(scb) + p - (MW - 1);
    f   = MW'(sum << (MW - p));

    // Encode as regime run + terminator + exponent + fraction, then round
    // the bit string to N-1 bits (ties to even).
    k       = nsc >>> es;
    e       = es'(nsc - (k <<< es));
    run_bit = (k >= 0);
    rm      = run_bit ? k + 1 : -k;
    xs      = {~run_bit, e, f, {(L - 1 - es - MW){1'b0}}};
    str     = (xs >> rm) | (run_bit ? ~({L{1'b1}} >> rm) : '0);
    field   = str[L-1 -: N-1];
    guard   = str[L-N];
    up      = guard & ((|str[L-N-1:0]) | field[0]);

    if (k > N - 2)         mag = {1'b0, {(N-1){1'b1}}};
    else if (k < -(N - 2)) mag = N'(1);
    else                   mag = {1'b0, field + (N-1)'(up)};

    inf = (in1 == {1'b1, {(N-1){1'b0}}}) || (in2 == {1'b1, {(N-1){1'b0}}});
    if (inf)             out = {1'b1, {(N-1){1'b0}}};
    else if (sum == '0)  out = '0;
    else                 out = sb ? (~mag + N'(1)) : mag;
  end

  assign done = start;

endmodule
`default_nettype wire

// File: rtl/posit_accum_seq.sv
`default_nettype none
// ============================================================================
// Module  : posit_accum_seq
// Purpose : Reduces each in_last-delimited group of posit operands to one
//           posit sum around the combinational adder posit_add_nodsp.
// Ports   : clk, rst_n (async, active-low)
//           bus.slave : in_valid/in_ready/in_data/in_last operand stream,
//                       out_valid/out_ready/out_data/out_inf/out_zero/
//                       out_count result stream
// Config  : POSIT_ACCUM_PIPE_EN - registers the adder result (sum_q) and
//           adds a WAIT state; one term per 2 cycles after the first.
// Revision: 1.0 - initial release
// ============================================================================
module posit_accum_seq
  import posit_pkg::*;
#(
  parameter int N     = 16,
  parameter int es    = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  posit_accum_seq_if.slave  bus
);
  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             nar_q, nar_d;
  logic [N-1:0]     add_out, sum_val;
  logic             add_inf, add_done, sum_nar, in_fire;
  logic             hold;

  posit_add_nodsp #(.N(N), .es(es)) u_add (
    .in1   (acc_q),
    .in2   (bus.in_data),
    .start (1'b1),
    .out   (add_out),
    .inf   (add_inf),
    .done  (add_done)
  );

  // Zero operands bypass the adder; NaR is sticky for the whole group.
  // start is tied high, so done is constantly 1.
  always_comb begin
    sum_val = add_out;
    sum_nar = 1'b0;
    if (nar_q || is_nar(acc_q) || is_nar(bus.in_data)) begin
      sum_val = NAR;
      sum_nar = 1'b1;
    end else if (is_zero(acc_q)) begin
      sum_val = bus.in_data;
    end else if (is_zero(bus.in_data)) begin
      sum_val = acc_q;
    end else if (add_inf || !add_done) begin
      sum_val = NAR;
      sum_nar = 1'b1;
    end
  end

  assign hold         = (state_q == ST_HOLD);
  assign bus.in_ready = rst_n & ((state_q == ST_IDLE) | (state_q == ST_ACC));
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign count_inc    = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  assign bus.out_valid = hold;
  assign bus.out_data  = hold ? acc_q : ZERO;
  assign bus.out_inf   = hold & nar_q;
  assign bus.out_zero  = hold & is_zero(acc_q);
  assign bus.out_count = hold ? count_q : '0;

`ifdef POSIT_ACCUM_PIPE_EN
  logic [N:0] sum_q, sum_d;   // {nar, sum}
  logic       last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      last_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    nar_d   = nar_q;
`ifdef POSIT_ACCUM_PIPE_EN
    sum_d   = sum_q;
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          acc_d   = bus.in_data;
          count_d = CNT_W'(1);
          nar_d   = is_nar(bus.in_data);
          state_d = bus.in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_fire) begin
          count_d = count_inc;
`ifdef POSIT_ACCUM_PIPE_EN
          sum_d   = {sum_nar, sum_val};
          last_d  = bus.in_last;
          state_d = ST_WAIT;
`else
          acc_d   = sum_val;
          nar_d   = sum_nar;
          state_d = bus.in_last ? ST_HOLD : ST_ACC;
`endif
        end
      end
`ifdef POSIT_ACCUM_PIPE_EN
      ST_WAIT: begin
        acc_d   = sum_q[N-1:0];
        nar_d   = sum_q[N];
        state_d = last_q ? ST_HOLD : ST_ACC;
      end
`endif
      ST_HOLD: begin
        if (bus.out_ready) begin
          acc_d   = ZERO;
          count_d = '0;
          nar_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= ZERO;
      count_q <= '0;
      nar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      nar_q   <= nar_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_accum_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_posit_accum_seq
// Purpose : Self-checking bench for posit_accum_seq: table of posit groups
//           with hand-computed sums (N=16, es=3), plus backpressure and
//           reset corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_posit_accum_seq;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef POSIT_ACCUM_PIPE_EN
  localparam int PIPE_LAT = 2;
`else
  localparam int PIPE_LAT = 1;
`endif

  posit_accum_seq_if #(.N(16), .CNT_W(16)) bus ();

  posit_accum_seq #(.N(16), .es(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string             name;
    int                n;
    logic [3:0][15:0]  d;
    logic [15:0]       exp_data;
    logic              exp_inf;
    logic              exp_zero;
    int                exp_cnt;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input string name, input int n,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [15:0] ed, input logic ei,
                              input logic ez, input int ec);
    vec_t v;
    v.name = name; v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.exp_data = ed; v.exp_inf = ei; v.exp_zero = ez; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] data, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'h5A5A;
  endtask

  // Called at posedge+1 right after the last beat was accepted.
  task automatic wait_result(input string name, input int exp_lat);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take_result(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_group(input vec_t v);
    for (int i = 0; i < v.n; i++) send_beat(v.d[i], (i == v.n - 1));
    wait_result(v.name, (v.n == 1) ? 1 : PIPE_LAT);
    chk({v.name, "_data"},  {16'd0, bus.out_data}, {16'd0, v.exp_data});
    chk({v.name, "_inf"},   {31'd0, bus.out_inf},  {31'd0, v.exp_inf});
    chk({v.name, "_zero"},  {31'd0, bus.out_zero}, {31'd0, v.exp_zero});
    chk({v.name, "_count"}, {16'd0, bus.out_count}, 32'(v.exp_cnt));
    take_result(v.name);
  endtask

  task automatic check_outputs_clear(input string name);
    chk({name, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
    chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_out_data"},  {16'd0, bus.out_data},  32'd0);
    chk({name, "_out_inf"},   {31'd0, bus.out_inf},   32'd0);
    chk({name, "_out_zero"},  {31'd0, bus.out_zero},  32'd0);
    chk({name, "_out_count"}, {16'd0, bus.out_count}, 32'd0);
  endtask

  initial begin
    // 1.0=4000 2.0=4400 4.0=4800 0.5=3C00 1.5=4200 -1=C000 -2=BC00 -4=B800
    vt[0]  = mk("one_plus_one",  2, 16'h4000, 16'h4000, 16'h0,    16'h0,    16'h4400, 1'b0, 1'b0, 2);
    vt[1]  = mk("cancel",        2, 16'h4000, 16'hC000, 16'h0,    16'h0,    16'h0000, 1'b0, 1'b1, 2);
    vt[2]  = mk("nar_sticky",    3, 16'h4000, 16'h8000, 16'h4000, 16'h0,    16'h8000, 1'b1, 1'b0, 3);
    vt[3]  = mk("single",        1, 16'h4000, 16'h0,    16'h0,    16'h0,    16'h4000, 1'b0, 1'b0, 1);
    vt[4]  = mk("zero_first",    2, 16'h0000, 16'h4400, 16'h0,    16'h0,    16'h4400, 1'b0, 1'b0, 2);
    vt[5]  = mk("four_ones",     4, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4800, 1'b0, 1'b0, 4);
    vt[6]  = mk("halves",        2, 16'h3C00, 16'h3C00, 16'h0,    16'h0,    16'h4000, 1'b0, 1'b0, 2);
    vt[7]  = mk("one_half",      2, 16'h4000, 16'h3C00, 16'h0,    16'h0,    16'h4200, 1'b0, 1'b0, 2);
    vt[8]  = mk("two_minus_one", 2, 16'h4400, 16'hC000, 16'h0,    16'h0,    16'h4000, 1'b0, 1'b0, 2);
    vt[9]  = mk("neg_sum",       2, 16'hBC00, 16'hBC00, 16'h0,    16'h0,    16'hB800, 1'b0, 1'b0, 2);
    vt[10] = mk("maxpos_sat",    2, 16'h7FFF, 16'h7FFF, 16'h0,    16'h0,    16'h7FFF, 1'b0, 1'b0, 2);
    vt[11] = mk("minpos",        2, 16'h0001, 16'h0001, 16'h0,    16'h0,    16'h0001, 1'b0, 1'b0, 2);
    vt[12] = mk("nar_first",     1, 16'h8000, 16'h0,    16'h0,    16'h0,    16'h8000, 1'b1, 1'b0, 1);
    vt[13] = mk("zero_second",   3, 16'h4200, 16'h0000, 16'h0000, 16'h0,    16'h4200, 1'b0, 1'b0, 3);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_group(vt[i]);

    // Backpressure: result held five cycles while an operand is offered.
    send_beat(16'h4000, 1'b0);
    send_beat(16'h4000, 1'b1);
    wait_result("bp", PIPE_LAT);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7000;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_out_data",  {16'd0, bus.out_data},  32'h4400);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("bp_count", {16'd0, bus.out_count}, 32'd2);
    take_result("bp");

    // Reset in the middle of a group: partial sum discarded.
    send_beat(16'h4000, 1'b0);
    send_beat(16'h4400, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_clear("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_group(mk("after_rst_mid", 1, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000, 1'b0, 1'b0, 1));

    // Reset while a result is pending: nothing is emitted.
    send_beat(16'h4400, 1'b1);
    chk("rst_hold_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_clear("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_group(mk("after_rst_hold", 2, 16'h3C00, 16'h4000, 16'h0, 16'h0, 16'h4200, 1'b0, 1'b0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
